// File: rtl/countersync_down_timer.sv
// countersync_down_timer
//   Loadable synchronous down-counter/timer. A load value is counted down to
//   zero on enabled edges; the terminal edge (Q going from 1) produces a
//   one-cycle Borrow pulse and either stops the counter in DONE (one-shot) or
//   restarts it from the reload register (auto-reload).
//
// Handshake/strobe semantics: there is no valid/ready pair. load_i is a
//   single-cycle strobe sampled on the rising edge and has priority over
//   everything else. en_i is a level qualifier sampled on every rising edge
//   and is only honoured in RUN.
//
// Ports
//   clk_i     system clock, rising edge active
//   rst_ni    asynchronous active-low reset
//   load_i    synchronous load strobe, captures d_i into Q and reload register
//   d_i       load value
//   en_i      count enable
//   reload_i  1 = auto-reload, 0 = one-shot (sampled at the terminal edge only)
//   q_o       current count (registered)
//   zero_o    Q == 0
//   borrow_o  one-cycle terminal-count pulse (registered)
//   busy_o    high while in RUN
//   done_o    one-shot completion flag, sticky until the next load
//   state_o   FSM state for observation (0 IDLE, 1 RUN, 2 DONE)
module countersync_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             reload_i,
  output logic [WIDTH-1:0] q_o,
  output logic             zero_o,
  output logic             borrow_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             borrow_q, borrow_d;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      r_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      r_q      <= r_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state and next-count logic
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    r_d      = r_q;
    borrow_d = 1'b0;
    if (load_i) begin
      // Load wins over a coincident terminal count; no Borrow for that edge.
      q_d     = d_i;
      r_d     = d_i;
      state_d = (d_i != CNT_ZERO) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (en_i) begin
            if (q_q == CNT_ONE) begin
              borrow_d = 1'b1;
              if (reload_i) begin
                q_d = r_q;
              end else begin
                q_d     = CNT_ZERO;
                state_d = ST_DONE;
              end
            end else begin
              q_d = q_q - CNT_ONE;
            end
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs; Done is exactly "in DONE", which is entered only from the
  // one-shot terminal edge and left only by a load.
  always_comb begin
    q_o      = q_q;
    zero_o   = (q_q == CNT_ZERO);
    borrow_o = borrow_q;
    busy_o   = (state_q == ST_RUN);
    done_o   = (state_q == ST_DONE);
    state_o  = state_q;
  end

endmodule

// File: tb/tb_countersync_down_timer.sv
module tb_countersync_down_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] d;
  logic         en;
  logic         reload;
  logic [W-1:0] q;
  logic         zero;
  logic         borrow;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         load;
    logic [W-1:0] d;
    logic         en;
    logic         reload;
    logic [W-1:0] exp_q;
    logic         exp_zero;
    logic         exp_borrow;
    logic         exp_busy;
    logic         exp_done;
    string        tag;
  } vec_t;

  vec_t vecs[$];

  countersync_down_timer #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (load),
    .d_i      (d),
    .en_i     (en),
    .reload_i (reload),
    .q_o      (q),
    .zero_o   (zero),
    .borrow_o (borrow),
    .busy_o   (busy),
    .done_o   (done),
    .state_o  (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] eq, input logic ez,
                           input logic eb, input logic ebusy, input logic ed);
    check({tag, ".q"},      32'(q),      32'(eq));
    check({tag, ".zero"},   32'(zero),   32'(ez));
    check({tag, ".borrow"}, 32'(borrow), 32'(eb));
    check({tag, ".busy"},   32'(busy),   32'(ebusy));
    check({tag, ".done"},   32'(done),   32'(ed));
  endtask

  // driver: apply inputs just after an edge, sample 1 time unit after the next
  task automatic step(input logic l, input logic [W-1:0] dv, input logic e, input logic r);
    load = l; d = dv; en = e; reload = r;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic l, input logic [W-1:0] dv, input logic e,
                              input logic r, input logic [W-1:0] eq, input logic eb,
                              input logic ebusy, input logic ed, input string tag);
    vec_t v;
    v.load = l; v.d = dv; v.en = e; v.reload = r;
    v.exp_q = eq; v.exp_zero = (eq == '0); v.exp_borrow = eb;
    v.exp_busy = ebusy; v.exp_done = ed; v.tag = tag;
    vecs.push_back(v);
  endfunction

  initial begin
    load = 0; d = '0; en = 0; reload = 0;

    // ---- reset: low for 30 ns while the clock runs ----
    rst_n = 1'b0;
    #10;
    check_all("rst_async", 4'd0, 1, 0, 0, 0);
    #20;
    rst_n = 1'b1;
    check_all("rst_release", 4'd0, 1, 0, 0, 0);
    step(0, 4'd0, 1, 0);
    check_all("rst_en_noload0", 4'd0, 1, 0, 0, 0);
    step(0, 4'd0, 1, 0);
    check_all("rst_en_noload1", 4'd0, 1, 0, 0, 0);

    // ---- vector table ----
    // one-shot 5
    add(1, 5, 1, 0, 5, 0, 1, 0, "os_load");
    add(0, 0, 1, 0, 4, 0, 1, 0, "os_4");
    add(0, 0, 1, 0, 3, 0, 1, 0, "os_3");
    add(0, 0, 1, 0, 2, 0, 1, 0, "os_2");
    add(0, 0, 1, 0, 1, 0, 1, 0, "os_1");
    add(0, 0, 1, 0, 0, 1, 0, 1, "os_term");
    add(0, 0, 1, 0, 0, 0, 0, 1, "os_after");
    // pause
    add(1, 4, 1, 0, 4, 0, 1, 0, "pa_load");
    add(0, 0, 1, 0, 3, 0, 1, 0, "pa_3");
    add(0, 0, 1, 0, 2, 0, 1, 0, "pa_2");
    add(0, 0, 0, 0, 2, 0, 1, 0, "pa_hold0");
    add(0, 0, 0, 0, 2, 0, 1, 0, "pa_hold1");
    add(0, 0, 0, 0, 2, 0, 1, 0, "pa_hold2");
    add(0, 0, 1, 0, 1, 0, 1, 0, "pa_1");
    add(0, 0, 1, 0, 0, 1, 0, 1, "pa_term");
    // auto-reload 3
    add(1, 3, 1, 1, 3, 0, 1, 0, "ar_load");
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 1, 1, 2, 0, 1, 0, "ar_2");
      add(0, 0, 1, 1, 1, 0, 1, 0, "ar_1");
      add(0, 0, 1, 1, 3, 1, 1, 0, "ar_reload");
    end
    // load on the terminal edge, then load of zero
    add(0, 0, 1, 1, 2, 0, 1, 0, "el_2");
    add(0, 0, 1, 1, 1, 0, 1, 0, "el_1");
    add(1, 7, 1, 1, 7, 0, 1, 0, "el_load7_at_term");
    add(1, 0, 1, 0, 0, 0, 0, 0, "el_load0");
    add(0, 0, 1, 0, 0, 0, 0, 0, "el_idle_en");
    // full-scale one-shot 15
    add(1, 15, 1, 0, 15, 0, 1, 0, "fs_load");
    for (int k = 14; k >= 1; k--) add(0, 0, 1, 0, 4'(k), 0, 1, 0, "fs_cnt");
    add(0, 0, 1, 0, 0, 1, 0, 1, "fs_term");
    // load from DONE, then R == 1 reload: borrow continuous
    add(1, 1, 1, 1, 1, 0, 1, 0, "r1_load");
    add(0, 0, 1, 1, 1, 1, 1, 0, "r1_b0");
    add(0, 0, 1, 1, 1, 1, 1, 0, "r1_b1");
    add(0, 0, 0, 1, 1, 0, 1, 0, "r1_pause");
    // reload sampled only at terminal edge
    add(1, 2, 1, 0, 2, 0, 1, 0, "rs_load");
    add(0, 0, 1, 0, 1, 0, 1, 0, "rs_1");
    add(0, 0, 1, 1, 2, 1, 1, 0, "rs_reload");
    add(0, 0, 1, 1, 1, 0, 1, 0, "rs_1b");
    add(0, 0, 1, 0, 0, 1, 0, 1, "rs_oneshot");

    foreach (vecs[i]) begin
      step(vecs[i].load, vecs[i].d, vecs[i].en, vecs[i].reload);
      check_all(vecs[i].tag, vecs[i].exp_q, vecs[i].exp_zero, vecs[i].exp_borrow,
                vecs[i].exp_busy, vecs[i].exp_done);
    end

    // ---- reset mid-count ----
    step(1, 9, 1, 0);
    check_all("mr_load", 4'd9, 0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check_all("mr_6", 4'd6, 0, 0, 1, 0);
    #5;
    rst_n = 1'b0;
    #1;
    check_all("mr_async", 4'd0, 1, 0, 0, 0);
    #10;
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    check_all("mr_after0", 4'd0, 1, 0, 0, 0);
    step(0, 0, 1, 0);
    check_all("mr_after1", 4'd0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
